// File: rtl/nvdla_cdp_rdma_req_gen.sv
// nvdla_cdp_rdma_req_gen: CDP read-request generator walking surface/line/width-burst under latency-FIFO credit control
module nvdla_cdp_rdma_req_gen #(
  parameter int ADDR_W = 64,
  parameter int ATOM_BYTES = 32,
  parameter int MAX_BURST = 8,
  parameter int LAT_CREDITS = 256,
  parameter int DIM_W = 13,
  parameter int STRIDE_W = ADDR_W,
  parameter int SZ_W = $clog2(MAX_BURST),
  parameter int CQ_W = SZ_W + 3
) (
  input  logic                   nvdla_core_clk,
  input  logic                   nvdla_core_rst,
  input  logic                   reg2dp_op_en,
  input  logic                   reg2dp_src_ram_type,
  input  logic [1:0]             reg2dp_input_data,
  input  logic [ADDR_W-1:0]      reg2dp_src_base_addr,
  input  logic [STRIDE_W-1:0]    reg2dp_src_line_stride,
  input  logic [STRIDE_W-1:0]    reg2dp_src_surface_stride,
  input  logic [DIM_W-1:0]       reg2dp_width,
  input  logic [DIM_W-1:0]       reg2dp_height,
  input  logic [DIM_W-1:0]       reg2dp_channel,
  output logic                   cdp2mcif_rd_req_valid,
  input  logic                   cdp2mcif_rd_req_ready,
  output logic [ADDR_W+SZ_W-1:0] cdp2mcif_rd_req_pd,
  output logic                   cdp2cvif_rd_req_valid,
  input  logic                   cdp2cvif_rd_req_ready,
  output logic [ADDR_W+SZ_W-1:0] cdp2cvif_rd_req_pd,
  input  logic                   rd_cdt_pop,
  output logic                   cq_wr_pvld,
  input  logic                   cq_wr_prdy,
  output logic [CQ_W-1:0]        cq_wr_pd,
  input  logic                   eg2ig_done,
  output logic [31:0]            dp2reg_perf_read_stall,
  output logic                   op_busy
);
  localparam int CR_W = $clog2(LAT_CREDITS + 1);
  typedef enum logic [1:0] {IDLE, RUN, WAIT_DONE} state_t;
  state_t state_q, state_d;
  logic op_en_q, op_en_d, ram_q, ram_d, slot_v_q, slot_v_d;
  logic [ADDR_W+SZ_W-1:0] slot_pd_q, slot_pd_d;
  logic [CR_W-1:0] cred_q, cred_d;
  logic [CR_W:0] cred_sum;
  logic [DIM_W-1:0] w_q, w_d, h_q, h_d, s_q, s_d, rem, s_last;
  logic [ADDR_W-1:0] addr_q, addr_d, line_q, line_d, surf_q, surf_d, line_nx, surf_nx;
  logic [31:0] stall_q, stall_d;
  logic start, sel_rdy, last_w, last_h, last_c, cred_ok, slot_free, load;
  logic [SZ_W-1:0] size;
  logic [SZ_W:0] atoms;
  always_comb begin
    start = state_q == IDLE && reg2dp_op_en && !op_en_q;
    sel_rdy = ram_q ? cdp2cvif_rd_req_ready : cdp2mcif_rd_req_ready;
    rem = reg2dp_width - w_q;
    s_last = reg2dp_input_data == 2'd0 ? reg2dp_channel >> 5 : reg2dp_channel >> 4;
    last_w = rem < DIM_W'(MAX_BURST);
    last_h = last_w && h_q == reg2dp_height;
    last_c = last_h && s_q == s_last;
    size = last_w ? rem[SZ_W-1:0] : SZ_W'(MAX_BURST - 1);
    atoms = {1'b0, size} + (SZ_W+1)'(1);
    cred_ok = cred_q >= CR_W'(atoms);
    slot_free = !slot_v_q || sel_rdy;
    cq_wr_pvld = state_q == RUN && cred_ok && slot_free;
    load = cq_wr_pvld && cq_wr_prdy;
    cq_wr_pd = {last_c, last_h, last_w, size};
    line_nx = line_q + ADDR_W'(reg2dp_src_line_stride);
    surf_nx = surf_q + ADDR_W'(reg2dp_src_surface_stride);
    cred_sum = {1'b0, cred_q} - (load ? (CR_W+1)'(atoms) : '0) + (CR_W+1)'(rd_cdt_pop);
  end
  always_comb begin
    state_d = start ? RUN : (state_q == RUN && load && last_c) ? WAIT_DONE
            : (state_q == WAIT_DONE && eg2ig_done) ? IDLE : state_q;
    op_en_d = reg2dp_op_en;
    ram_d = start ? reg2dp_src_ram_type : ram_q;
    w_d = start ? '0 : load ? (last_w ? '0 : w_q + DIM_W'(MAX_BURST)) : w_q;
    h_d = start ? '0 : (load && last_w) ? (last_h ? '0 : h_q + DIM_W'(1)) : h_q;
    s_d = start ? '0 : (load && last_h) ? s_q + DIM_W'(1) : s_q;
    surf_d = start ? reg2dp_src_base_addr : (load && last_h) ? surf_nx : surf_q;
    line_d = start ? reg2dp_src_base_addr : (load && last_h) ? surf_nx : (load && last_w) ? line_nx : line_q;
    addr_d = start ? reg2dp_src_base_addr : (load && last_h) ? surf_nx : (load && last_w) ? line_nx
           : load ? addr_q + ADDR_W'(MAX_BURST * ATOM_BYTES) : addr_q;
    slot_v_d = load || (slot_v_q && !sel_rdy);
    slot_pd_d = load ? {size, addr_q} : slot_pd_q;
    cred_d = cred_sum > (CR_W+1)'(LAT_CREDITS) ? CR_W'(LAT_CREDITS) : cred_sum[CR_W-1:0];
    stall_d = start ? '0 : (slot_v_q && !sel_rdy && stall_q != '1) ? stall_q + 32'd1 : stall_q;
  end
  always_ff @(posedge nvdla_core_clk) begin
    if (nvdla_core_rst) begin
      state_q <= IDLE;
      op_en_q <= 1'b0;
      ram_q <= 1'b0;
      w_q <= '0;
      h_q <= '0;
      s_q <= '0;
      surf_q <= '0;
      line_q <= '0;
      addr_q <= '0;
      slot_v_q <= 1'b0;
      slot_pd_q <= '0;
      cred_q <= CR_W'(LAT_CREDITS);
      stall_q <= '0;
    end else begin
      state_q <= state_d;
      op_en_q <= op_en_d;
      ram_q <= ram_d;
      w_q <= w_d;
      h_q <= h_d;
      s_q <= s_d;
      surf_q <= surf_d;
      line_q <= line_d;
      addr_q <= addr_d;
      slot_v_q <= slot_v_d;
      slot_pd_q <= slot_pd_d;
      cred_q <= cred_d;
      stall_q <= stall_d;
    end
  end
  always_ff @(posedge nvdla_core_clk) begin
    if (!nvdla_core_rst) assert (!(rd_cdt_pop && cred_q == CR_W'(LAT_CREDITS) && !load));
  end
  assign cdp2mcif_rd_req_valid = slot_v_q & ~ram_q;
  assign cdp2cvif_rd_req_valid = slot_v_q & ram_q;
  assign cdp2mcif_rd_req_pd = slot_pd_q;
  assign cdp2cvif_rd_req_pd = slot_pd_q;
  assign dp2reg_perf_read_stall = stall_q;
  assign op_busy = state_q != IDLE;
endmodule
